// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared screen size, geometry widths and fragment type
// Shared by the line rasterizer and the framebuffer.
package gpu_pkg;

  localparam int H_RES = 320;
  localparam int V_RES = 240;

  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int Z_W   = 8;
  localparam int RGB_W = 12;

  typedef logic [X_W-1:0]   x_t;
  typedef logic [Y_W-1:0]   y_t;
  typedef logic [Z_W-1:0]   z_t;
  typedef logic [RGB_W-1:0] rgb_t;

  typedef struct packed {
    x_t   x;
    y_t   y;
    z_t   z;
    rgb_t rgb;
  } frag_t;

endpackage

// File: rtl/line_rasterizer.sv
// rtl/line_rasterizer.sv - Bresenham line rasterizer, one fragment step per cycle
// Flat depth and colour; steps outside the visible area are clipped but still take a cycle.
module line_rasterizer #(
  parameter int H_RES = gpu_pkg::H_RES,
  parameter int V_RES = gpu_pkg::V_RES
) (
  input  logic                      gpu_clk_in,
  input  logic                      rst_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [gpu_pkg::X_W-1:0]   x0_in,
  input  logic [gpu_pkg::X_W-1:0]   x1_in,
  input  logic [gpu_pkg::Y_W-1:0]   y0_in,
  input  logic [gpu_pkg::Y_W-1:0]   y1_in,
  input  logic [gpu_pkg::Z_W-1:0]   z_in,
  input  logic [gpu_pkg::RGB_W-1:0] rgb_in,
  output logic                      valid_out,
  output logic [gpu_pkg::X_W-1:0]   x_out,
  output logic [gpu_pkg::Y_W-1:0]   y_out,
  output logic [gpu_pkg::Z_W-1:0]   z_out,
  output logic [gpu_pkg::RGB_W-1:0] rgb_out,
  output logic                      done_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;

  localparam logic signed [11:0] H_LIM = 12'(H_RES);
  localparam logic signed [11:0] V_LIM = 12'(V_RES);

  logic [1:0] state;

  gpu_pkg::x_t   x0_q, x1_q;
  gpu_pkg::y_t   y0_q, y1_q;
  gpu_pkg::z_t   z_q;
  gpu_pkg::rgb_t rgb_q;

  logic signed [11:0] dx, dy, err, sx, sy, cur_x, cur_y;
  logic signed [11:0] x0_s, x1_s, y0_s, y1_s;
  logic signed [11:0] e2, err_n, nx, ny;
  logic               at_end, on_screen;

  gpu_pkg::frag_t frag_q;

  assign x0_s = signed'({3'b000, x0_q});
  assign x1_s = signed'({3'b000, x1_q});
  assign y0_s = signed'({4'b0000, y0_q});
  assign y1_s = signed'({4'b0000, y1_q});

  assign ready_out = (state == S_IDLE);
  assign at_end    = (cur_x == x1_s) && (cur_y == y1_s);
  // Coordinates never go negative between endpoints, so an upper bound is enough to clip.
  assign on_screen = (cur_x < H_LIM) && (cur_y < V_LIM);

  // Both Bresenham updates are evaluated against the same e2 and applied together.
  always_comb begin
    e2    = err <<< 1;
    err_n = err;
    nx    = cur_x;
    ny    = cur_y;
    if (e2 >= dy) begin
      err_n = err_n + dy;
      nx    = cur_x + sx;
    end
    if (e2 <= dx) begin
      err_n = err_n + dx;
      ny    = cur_y + sy;
    end
  end

  assign x_out   = frag_q.x;
  assign y_out   = frag_q.y;
  assign z_out   = frag_q.z;
  assign rgb_out = frag_q.rgb;

  always_ff @(posedge gpu_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      z_q       <= '0;
      rgb_q     <= '0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      sx        <= '0;
      sy        <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      frag_q    <= '0;
      valid_out <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          valid_out <= 1'b0;
          done_out  <= 1'b0;
          if (valid_in) begin
            x0_q  <= x0_in;
            x1_q  <= x1_in;
            y0_q  <= y0_in;
            y1_q  <= y1_in;
            z_q   <= z_in;
            rgb_q <= rgb_in;
            state <= S_SETUP;
          end
        end

        S_SETUP: begin
          valid_out <= 1'b0;
          done_out  <= 1'b0;
          if (x1_s >= x0_s) begin
            dx <= x1_s - x0_s;
            sx <= 12'sd1;
          end else begin
            dx <= x0_s - x1_s;
            sx <= -12'sd1;
          end
          if (y1_s >= y0_s) begin
            dy  <= y0_s - y1_s;
            sy  <= 12'sd1;
          end else begin
            dy  <= y1_s - y0_s;
            sy  <= -12'sd1;
          end
          err   <= ((x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s))
                 - ((y1_s >= y0_s) ? (y1_s - y0_s) : (y0_s - y1_s));
          cur_x <= x0_s;
          cur_y <= y0_s;
          state <= S_DRAW;
        end

        S_DRAW: begin
          frag_q.x   <= cur_x[gpu_pkg::X_W-1:0];
          frag_q.y   <= cur_y[gpu_pkg::Y_W-1:0];
          frag_q.z   <= z_q;
          frag_q.rgb <= rgb_q;
          valid_out  <= on_screen;
          done_out   <= at_end;
          if (at_end) begin
            state <= S_IDLE;
          end else begin
            err   <= err_n;
            cur_x <= nx;
            cur_y <= ny;
          end
        end

        default: begin
          state     <= S_IDLE;
          valid_out <= 1'b0;
          done_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// tb/tb_line_rasterizer.sv - directed self-checking bench for line_rasterizer
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_line_rasterizer;

  logic        gpu_clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        ready_out;
  logic [8:0]  x0_in, x1_in;
  logic [7:0]  y0_in, y1_in;
  logic [7:0]  z_in;
  logic [11:0] rgb_in;
  logic        valid_out;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic [7:0]  z_out;
  logic [11:0] rgb_out;
  logic        done_out;

  int tests = 0;
  int fails = 0;
  int seen;
  logic [7:0]  exp_z;
  logic [11:0] exp_rgb;

  line_rasterizer dut (
    .gpu_clk_in (gpu_clk_in),
    .rst_in     (rst_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .x0_in      (x0_in),
    .x1_in      (x1_in),
    .y0_in      (y0_in),
    .y1_in      (y1_in),
    .z_in       (z_in),
    .rgb_in     (rgb_in),
    .valid_out  (valid_out),
    .x_out      (x_out),
    .y_out      (y_out),
    .z_out      (z_out),
    .rgb_out    (rgb_out),
    .done_out   (done_out)
  );

  always #5 gpu_clk_in = ~gpu_clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gpu_clk_in);
    #1;
  endtask

  // Present a command and step through the acceptance edge and the SETUP cycle.
  task automatic send_cmd(input string tag, input int ax0, input int ay0, input int ax1,
                          input int ay1, input logic [7:0] z, input logic [11:0] rgb);
    x0_in = 9'(ax0); y0_in = 8'(ay0); x1_in = 9'(ax1); y1_in = 8'(ay1);
    z_in = z; rgb_in = rgb; valid_in = 1'b1;
    exp_z = z; exp_rgb = rgb;
    chk({tag, " ready_before"}, 32'(ready_out), 32'd1);
    tick();
    valid_in = 1'b0;
    chk({tag, " ready_setup"}, 32'(ready_out), 32'd0);
    chk({tag, " valid_setup"}, 32'(valid_out), 32'd0);
    tick();
    chk({tag, " valid_n1"}, 32'(valid_out), 32'd0);
    chk({tag, " done_n1"}, 32'(done_out), 32'd0);
  endtask

  task automatic expect_step(input string tag, input logic v, input int ex, input int ey,
                             input logic d);
    tick();
    chk({tag, " valid"}, 32'(valid_out), 32'(v));
    chk({tag, " done"}, 32'(done_out), 32'(d));
    chk({tag, " ready"}, 32'(ready_out), 32'(d));
    if (v) begin
      chk({tag, " x"}, 32'(x_out), 32'(ex));
      chk({tag, " y"}, 32'(y_out), 32'(ey));
      chk({tag, " z"}, 32'(z_out), 32'(exp_z));
      chk({tag, " rgb"}, 32'(rgb_out), 32'(exp_rgb));
    end
  endtask

  task automatic expect_idle(input string tag);
    tick();
    chk({tag, " idle_valid"}, 32'(valid_out), 32'd0);
    chk({tag, " idle_done"}, 32'(done_out), 32'd0);
    chk({tag, " idle_ready"}, 32'(ready_out), 32'd1);
  endtask

  initial begin
    rst_in = 1'b1; valid_in = 1'b0;
    x0_in = '0; x1_in = '0; y0_in = '0; y1_in = '0; z_in = '0; rgb_in = '0;
    exp_z = '0; exp_rgb = '0;
    tick();
    chk("rst valid", 32'(valid_out), 32'd0);
    chk("rst done", 32'(done_out), 32'd0);
    chk("rst ready", 32'(ready_out), 32'd1);
    chk("rst x", 32'(x_out), 32'd0);
    chk("rst rgb", 32'(rgb_out), 32'd0);
    tick();
    rst_in = 1'b0;
    expect_idle("post_rst");

    // Horizontal line left to right.
    send_cmd("h_fwd", 10, 20, 14, 20, 8'h33, 12'hABC);
    expect_step("h_fwd s0", 1'b1, 10, 20, 1'b0);
    expect_step("h_fwd s1", 1'b1, 11, 20, 1'b0);
    expect_step("h_fwd s2", 1'b1, 12, 20, 1'b0);
    expect_step("h_fwd s3", 1'b1, 13, 20, 1'b0);
    expect_step("h_fwd s4", 1'b1, 14, 20, 1'b1);
    expect_idle("h_fwd");

    // Steep line.
    send_cmd("steep", 0, 0, 2, 5, 8'h5A, 12'h123);
    expect_step("steep s0", 1'b1, 0, 0, 1'b0);
    expect_step("steep s1", 1'b1, 0, 1, 1'b0);
    expect_step("steep s2", 1'b1, 1, 2, 1'b0);
    expect_step("steep s3", 1'b1, 1, 3, 1'b0);
    expect_step("steep s4", 1'b1, 2, 4, 1'b0);
    expect_step("steep s5", 1'b1, 2, 5, 1'b1);
    expect_idle("steep");

    // Horizontal line right to left.
    send_cmd("h_rev", 14, 20, 10, 20, 8'h01, 12'hF0F);
    expect_step("h_rev s0", 1'b1, 14, 20, 1'b0);
    expect_step("h_rev s1", 1'b1, 13, 20, 1'b0);
    expect_step("h_rev s2", 1'b1, 12, 20, 1'b0);
    expect_step("h_rev s3", 1'b1, 11, 20, 1'b0);
    expect_step("h_rev s4", 1'b1, 10, 20, 1'b1);
    expect_idle("h_rev");

    // Zero-length line.
    send_cmd("point", 5, 5, 5, 5, 8'hEE, 12'h0F0);
    expect_step("point s0", 1'b1, 5, 5, 1'b1);
    expect_idle("point");

    // Upward diagonal: negative y step.
    send_cmd("diag_up", 3, 9, 6, 6, 8'h10, 12'h777);
    expect_step("diag_up s0", 1'b1, 3, 9, 1'b0);
    expect_step("diag_up s1", 1'b1, 4, 8, 1'b0);
    expect_step("diag_up s2", 1'b1, 5, 7, 1'b0);
    expect_step("diag_up s3", 1'b1, 6, 6, 1'b1);
    expect_idle("diag_up");

    // Crosses the right edge: last three steps clipped.
    send_cmd("clip", 318, 100, 322, 100, 8'h44, 12'h456);
    expect_step("clip s0", 1'b1, 318, 100, 1'b0);
    expect_step("clip s1", 1'b1, 319, 100, 1'b0);
    expect_step("clip s2", 1'b0, 320, 100, 1'b0);
    expect_step("clip s3", 1'b0, 321, 100, 1'b0);
    expect_step("clip s4", 1'b0, 322, 100, 1'b1);
    expect_idle("clip");

    // Bottom edge clip on y.
    send_cmd("clip_y", 7, 240, 7, 240, 8'h00, 12'h001);
    expect_step("clip_y s0", 1'b0, 7, 240, 1'b1);
    expect_idle("clip_y");

    // valid_in held through DRAW with new operands: second command waits for IDLE.
    send_cmd("hold_a", 10, 20, 14, 20, 8'h33, 12'hABC);
    valid_in = 1'b1;
    x0_in = 9'd30; y0_in = 8'd40; x1_in = 9'd31; y1_in = 8'd40;
    z_in = 8'h99; rgb_in = 12'h321;
    expect_step("hold_a s0", 1'b1, 10, 20, 1'b0);
    expect_step("hold_a s1", 1'b1, 11, 20, 1'b0);
    expect_step("hold_a s2", 1'b1, 12, 20, 1'b0);
    expect_step("hold_a s3", 1'b1, 13, 20, 1'b0);
    expect_step("hold_a s4", 1'b1, 14, 20, 1'b1);
    tick();
    valid_in = 1'b0;
    chk("hold_b accepted", 32'(ready_out), 32'd0);
    chk("hold_b setup_valid", 32'(valid_out), 32'd0);
    tick();
    chk("hold_b n1_valid", 32'(valid_out), 32'd0);
    exp_z = 8'h99; exp_rgb = 12'h321;
    expect_step("hold_b s0", 1'b1, 30, 40, 1'b0);
    expect_step("hold_b s1", 1'b1, 31, 40, 1'b1);
    expect_idle("hold_b");

    // Reset mid-line: valid_out drops asynchronously and the line is discarded.
    send_cmd("mid_rst", 0, 0, 10, 0, 8'h22, 12'h888);
    expect_step("mid_rst s0", 1'b1, 0, 0, 1'b0);
    expect_step("mid_rst s1", 1'b1, 1, 0, 1'b0);
    rst_in = 1'b1;
    #1;
    chk("mid_rst async_valid", 32'(valid_out), 32'd0);
    chk("mid_rst async_ready", 32'(ready_out), 32'd1);
    chk("mid_rst async_x", 32'(x_out), 32'd0);
    tick();
    rst_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (valid_out || done_out) seen++;
    end
    chk("mid_rst no_frags", 32'(seen), 32'd0);
    chk("mid_rst ready", 32'(ready_out), 32'd1);

    // Rasterizer is usable again after the reset.
    send_cmd("after_rst", 2, 3, 3, 3, 8'h7F, 12'hFFF);
    expect_step("after_rst s0", 1'b1, 2, 3, 1'b0);
    expect_step("after_rst s1", 1'b1, 3, 3, 1'b1);
    expect_idle("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_rasterizer.md
LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 SHALL have parameter H_RES, default 320, visible width in pixels.
REQ-002 SHALL have parameter V_RES, default 240, visible height in pixels.
REQ-003 SHALL have port gpu_clk_in  input  1  GPU clock; the only clock.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid_in  input  1  line command valid.
REQ-006 SHALL have port ready_out  output  1  command accepted when valid_in and ready_out are both high at a rising edge.
REQ-007 SHALL have ports x0_in, x1_in  input  9  endpoint x coordinates.
REQ-008 SHALL have ports y0_in, y1_in  input  8  endpoint y coordinates.
REQ-009 SHALL have port z_in  input  8  depth, flat across the line.
REQ-010 SHALL have port rgb_in  input  12  colour, flat across the line.
REQ-011 SHALL have port valid_out  output  1  fragment valid (framebuffer valid_in).
REQ-012 SHALL have port x_out  output  9  fragment x.
REQ-013 SHALL have port y_out  output  8  fragment y.
REQ-014 SHALL have port z_out  output  8  fragment depth.
REQ-015 SHALL have port rgb_out  output  12  fragment colour.
REQ-016 SHALL have port done_out  output  1  one-cycle pulse on the last step of a line.

Function
REQ-017 SHALL implement FSM IDLE -> SETUP -> DRAW -> IDLE; ready_out high only in IDLE.
REQ-018 On acceptance, SHALL latch x0, y0, x1, y1, z and rgb; go to SETUP; valid_in outside IDLE is ignored.
REQ-019 In SETUP (one cycle), SHALL compute dx = |x1-x0|, dy = -|y1-y0|, sx/sy = +1/-1 by endpoint order, err = dx+dy; signed 12-bit arithmetic; then enter DRAW.
REQ-020 In DRAW, SHALL emit one step per cycle with no backpressure, registered outputs, standard Bresenham: e2 = 2*err; if e2 >= dy then err += dy, x += sx; if e2 <= dx then err += dx, y += sy; both updates apply in the same cycle.
REQ-021 SHALL make the first step visible on the outputs 2 cycles after the acceptance edge; the line SHALL take max(dx,-dy)+1 steps.
REQ-022 SHALL set valid_out high for a step only if x < H_RES and y < V_RES; off-screen steps still consume a cycle with valid_out low (clipping).
REQ-023 SHALL hold x_out, y_out, z_out and rgb_out at the current step value whenever valid_out is high; their values are don't-care while valid_out is low.
REQ-024 SHALL assert done_out on the step where (x,y) == (x1,y1), whether or not valid_out is high; FSM returns to IDLE on that same edge, so ready_out is high the next cycle.
REQ-025 Zero-length line (x0==x1, y0==y1) SHALL produce exactly one step, with done_out set on that step.
REQ-026 done_out and valid_out SHALL be low in IDLE and SETUP.

Reset
REQ-027 While rst_in is high, SHALL immediately (asynchronously) force state IDLE, valid_out 0, done_out 0 and all datapath registers 0, including mid-line; the current line is discarded.
REQ-028 ready_out SHALL be high in the first cycle after rst_in deasserts.

Structure
REQ-029 H_RES, V_RES, the coordinate, depth and colour widths, and a fragment struct type {x,y,z,rgb} SHALL be placed in shared package gpu_pkg, for use by the framebuffer as well.
REQ-030 SHALL be a single module; no sub-module is needed (the abs/sign setup is inline).

Verification
REQ-031 Command (10,20)->(14,20), acceptance at edge N -> valid_out on edges N+2..N+6 with x=10..14, y=20; done_out at N+6; ready_out high at N+7.
REQ-032 Command (0,0)->(2,5) -> fragments (0,0),(0,1),(1,2),(1,3),(2,4),(2,5) on consecutive cycles; done_out on (2,5).
REQ-033 Command (14,20)->(10,20) -> x=14,13,12,11,10 with y=20; command (5,5)->(5,5) -> one fragment with done_out.
REQ-034 Command (318,100)->(322,100) -> 5 step cycles; valid_out high only for x=318 and x=319; done_out on the 5th step with valid_out low.
REQ-035 Hold valid_in high for a second command during DRAW -> that command is accepted only after return to IDLE; rst_in pulsed mid-line -> valid_out drops in the same cycle and no further fragments appear.
